overflow_interval_ctrl: RTL and testbench

- Write-side controller for the overflow-interval circular buffer.
- Arbitrates interval submissions from two requesters: port 0 is the hardware overflow detector, port 1 is the CSR/software path.
- Drops malformed intervals and coalesces overlapping or adjacent intervals into one pending entry.
- Emits single-cycle write strobes (en_write, first, last) to the buffer, which saves buffer slots and keeps the oldest-overwrite policy meaningful.

---
 rtl/overflow_interval_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_overflow_interval_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overflow_interval_ctrl.sv
// Write-side controller for the overflow-interval circular buffer.
// Define OVF_CTRL_STATS_EN to add write/merge/drop statistics counters.
module overflow_interval_ctrl #(
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned BUF_SIZE = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_first_i,
  input  logic [31:0] req0_last_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_first_i,
  input  logic [31:0] req1_last_i,
  input  logic        flush_i,
  output logic        flush_done_o,
  output logic        buf_wr_o,
  output logic [31:0] buf_first_o,
  output logic [31:0] buf_last_o,
  output logic [5:0]  occupancy_o,
  output logic        pending_o
`ifdef OVF_CTRL_STATS_EN
  ,
  output logic [31:0] stat_writes_o,
  output logic [31:0] stat_merges_o,
  output logic [31:0] stat_drops_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic [31:0] first;
    logic [31:0] last;
  } ivl_t;

  localparam logic [31:0] TMAX    = 32'(TIMEOUT - 1);
  localparam logic [5:0]  OCC_MAX = 6'(BUF_SIZE);

  state_e      state_q, state_d;
  ivl_t        pend_q, pend_d;
  ivl_t        wrv_q, wrv_d;
  ivl_t        in_ivl, merged;
  logic [31:0] timer_q, timer_d;
  logic        rr_q, rr_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic [5:0]  occ_q;
  logic        open, gnt0, gnt1;
  logic        acc, bad, mergeable;
  logic [32:0] pend_last1, in_last1;

  // rr_q=0 favours req0 when both ports are valid
  assign open = !flush_i && (state_q != S_FLUSH);
  assign gnt0 = req0_valid_i && (!req1_valid_i || !rr_q);
  assign gnt1 = req1_valid_i && (!req0_valid_i || rr_q);

  assign req0_ready_o = open && gnt0;
  assign req1_ready_o = open && gnt1;
  assign acc = req0_ready_o || req1_ready_o;

  assign in_ivl = req1_ready_o ? {req1_first_i, req1_last_i}
                               : {req0_first_i, req0_last_i};
  assign bad = in_ivl.first > in_ivl.last;

  // 33-bit so that last=0xFFFFFFFF does not wrap to 0
  assign pend_last1 = {1'b0, pend_q.last} + 33'd1;
  assign in_last1   = {1'b0, in_ivl.last} + 33'd1;
  assign mergeable  = ({1'b0, in_ivl.first} <= pend_last1) &&
                      (in_last1 >= {1'b0, pend_q.first});

  assign merged.first = (in_ivl.first < pend_q.first) ?
                        in_ivl.first : pend_q.first;
  assign merged.last  = (in_ivl.last > pend_q.last) ?
                        in_ivl.last : pend_q.last;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    timer_d = timer_q;
    rr_d    = rr_q;
    wr_d    = 1'b0;
    wrv_d   = wrv_q;
    done_d  = 1'b0;
    if (acc) rr_d = gnt0;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_FLUSH;
        end else if (acc && !bad) begin
          pend_d  = in_ivl;
          timer_d = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          wr_d    = 1'b1;
          wrv_d   = pend_q;
          timer_d = '0;
          state_d = S_FLUSH;
        end else if (acc) begin
          if (!bad) begin
            timer_d = '0;
            if (mergeable) begin
              pend_d = merged;
            end else begin
              wr_d   = 1'b1;
              wrv_d  = pend_q;
              pend_d = in_ivl;
            end
          end
        end else if (TIMEOUT != 0 && timer_q == TMAX) begin
          wr_d    = 1'b1;
          wrv_d   = pend_q;
          timer_d = '0;
          state_d = S_IDLE;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_FLUSH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      wrv_q   <= '0;
      timer_q <= '0;
      rr_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wrv_q   <= wrv_d;
      timer_q <= timer_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      if (wr_d && occ_q != OCC_MAX) occ_q <= occ_q + 6'd1;
    end
  end

  assign buf_wr_o     = wr_q;
  assign buf_first_o  = wrv_q.first;
  assign buf_last_o   = wrv_q.last;
  assign flush_done_o = done_q;
  assign occupancy_o  = occ_q;
  assign pending_o    = state_q == S_HOLD;

`ifdef OVF_CTRL_STATS_EN
  logic [31:0] swr_q, smg_q, sdr_q;
  logic        merge_ev, drop_ev;

  assign drop_ev  = acc && bad;
  assign merge_ev = acc && !bad && state_q == S_HOLD && mergeable;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      swr_q <= '0;
      smg_q <= '0;
      sdr_q <= '0;
    end else begin
      if (wr_d)     swr_q <= swr_q + 32'd1;
      if (merge_ev) smg_q <= smg_q + 32'd1;
      if (drop_ev)  sdr_q <= sdr_q + 32'd1;
    end
  end

  assign stat_writes_o = swr_q;
  assign stat_merges_o = smg_q;
  assign stat_drops_o  = sdr_q;
`endif

endmodule

// File: tb/tb_overflow_interval_ctrl.sv
// Bench for overflow_interval_ctrl: directed steps plus random traffic
// checked against an interval-level model of the write stream.
module tb_overflow_interval_ctrl;
  localparam int TO = 16;
  localparam int BS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, fl;
  logic [31:0] f0, l0, f1, l1;
  logic        r0, r1, done, wr, pend;
  logic [31:0] wf, wl;
  logic [5:0]  occ;
`ifdef OVF_CTRL_STATS_EN
  logic [31:0] s_wr, s_mg, s_dr;
`endif

  always #5 clk = ~clk;

  overflow_interval_ctrl #(.TIMEOUT(TO), .BUF_SIZE(BS)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(r0),
    .req0_first_i(f0), .req0_last_i(l0),
    .req1_valid_i(v1), .req1_ready_o(r1),
    .req1_first_i(f1), .req1_last_i(l1),
    .flush_i(fl), .flush_done_o(done),
    .buf_wr_o(wr), .buf_first_o(wf), .buf_last_o(wl),
    .occupancy_o(occ), .pending_o(pend)
`ifdef OVF_CTRL_STATS_EN
    , .stat_writes_o(s_wr), .stat_merges_o(s_mg),
    .stat_drops_o(s_dr)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // model: pending interval, idle count, rr preference
  bit              m_have, m_rr, m_flushing;
  longint unsigned m_pf, m_pl;
  int              m_idle, m_occ;
  int              m_writes, m_merges, m_drops;
  bit              e_wr, e_done;
  longint unsigned e_wf, e_wl;

  // observation log, indexed by the cycle inputs are driven in
  int          cyc_n, wr_cnt, wr_cyc, done_cyc, acc_cyc;
  logic [31:0] last_wf, last_wl;
  bit          acc_port, obs_r0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_have = 0; m_rr = 0; m_flushing = 0;
    m_pf = 0; m_pl = 0; m_idle = 0; m_occ = 0;
    m_writes = 0; m_merges = 0; m_drops = 0;
  endtask

  task automatic emit(input longint unsigned f, input longint unsigned l);
    e_wr = 1; e_wf = f; e_wl = l;
    if (m_occ < BS) m_occ++;
    m_writes++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_first"}, wf, 0);
    chk({tag, "_last"}, wl, 0);
    chk({tag, "_occ"}, occ, 0);
    chk({tag, "_pend"}, pend, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdy"}, {r0, r1}, 0);
`ifdef OVF_CTRL_STATS_EN
    chk({tag, "_stats"}, {s_wr, s_mg | s_dr}, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    {v0, v1, fl} = 3'b000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cyc(input bit iv0, input logic [31:0] if0,
                     input logic [31:0] il0, input bit iv1,
                     input logic [31:0] if1, input logic [31:0] il1,
                     input bit ifl);
    bit g0, g1, open;
    longint unsigned nf, nl;
    @(negedge clk);
    cyc_n++;
    v0 = iv0; f0 = if0; l0 = il0;
    v1 = iv1; f1 = if1; l1 = il1;
    fl = ifl;
    #1;
    open = !ifl && !m_flushing;
    g0 = open && iv0 && (!iv1 || !m_rr);
    g1 = open && iv1 && (!iv0 || m_rr);
    chk("req0_ready", r0, g0);
    chk("req1_ready", r1, g1);
    chk("one_ready", r0 & r1, 0);
    obs_r0 = r0;
    @(posedge clk);
    #1;
    e_wr = 0; e_done = 0;
    if (m_flushing) begin
      m_flushing = 0;
      e_done = 1;
    end else if (ifl) begin
      if (m_have) emit(m_pf, m_pl);
      m_have = 0;
      m_flushing = 1;
    end else if (g0 || g1) begin
      acc_cyc = cyc_n;
      acc_port = g1;
      nf = g1 ? if1 : if0;
      nl = g1 ? il1 : il0;
      m_rr = g0;
      if (nf > nl) begin
        m_drops++;
      end else if (!m_have) begin
        m_have = 1; m_pf = nf; m_pl = nl; m_idle = 0;
      end else if (nf <= m_pl + 1 && nl + 1 >= m_pf) begin
        if (nf < m_pf) m_pf = nf;
        if (nl > m_pl) m_pl = nl;
        m_idle = 0;
        m_merges++;
      end else begin
        emit(m_pf, m_pl);
        m_pf = nf; m_pl = nl; m_idle = 0;
      end
    end else if (m_have) begin
      m_idle++;
      if (m_idle == TO) begin
        emit(m_pf, m_pl);
        m_have = 0;
      end
    end
    chk("buf_wr", wr, e_wr);
    if (e_wr) begin
      chk("buf_first", wf, e_wf);
      chk("buf_last", wl, e_wl);
    end
    chk("pending", pend, m_have);
    chk("occupancy", occ, m_occ);
    chk("flush_done", done, e_done);
`ifdef OVF_CTRL_STATS_EN
    chk("stat_writes", s_wr, m_writes);
    chk("stat_merges", s_mg, m_merges);
    chk("stat_drops", s_dr, m_drops);
`endif
    if (wr) begin
      wr_cnt++;
      wr_cyc = cyc_n + 1;
      last_wf = wf;
      last_wl = wl;
    end
    if (done) done_cyc = cyc_n + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rq0(input logic [31:0] f, input logic [31:0] l);
    cyc(1, f, l, 0, 0, 0, 0);
  endtask

  task automatic flush();
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic void rnd_ivl(output logic [31:0] f,
                                  output logic [31:0] l);
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) begin
      f = $urandom_range(32, 400);
      l = f - $urandom_range(1, 16);
    end else if (k == 1) begin
      l = 32'hFFFF_FFFF;
      f = l - $urandom_range(0, 255);
    end else if (k == 2) begin
      f = $urandom_range(0, 8);
      l = f + $urandom_range(0, 16);
    end else begin
      f = $urandom_range(0, 1023);
      l = f + $urandom_range(0, 63);
    end
  endfunction

  initial begin
    int w0, fc, drops0;
    bit port_q[$];
    logic [31:0] a, b, c, d;
    rst_n = 1'b1;
    {v0, v1, fl} = 3'b000;
    {f0, l0, f1, l1} = '0;
    cyc_n = 0; wr_cnt = 0;
    wr_cyc = 0; done_cyc = 0; acc_cyc = 0;
    model_reset();
    do_reset();

    // adjacent intervals coalesce; flush writes one entry
    w0 = wr_cnt;
    rq0(32'h1000, 32'h100F);
    rq0(32'h1010, 32'h101F);
    flush();
    fc = cyc_n;
    idle(2);
    chk("t1_writes", wr_cnt - w0, 1);
    chk("t1_first", last_wf, 32'h1000);
    chk("t1_last", last_wl, 32'h101F);
    chk("t1_done_lat", done_cyc - fc, 2);
    chk("t1_occ", occ, 1);

    // disjoint interval pushes out the old pending one
    w0 = wr_cnt;
    rq0(32'h2000, 32'h20FF);
    rq0(32'h3000, 32'h30FF);
    chk("t2_writes", wr_cnt - w0, 1);
    chk("t2_wr_lat", wr_cyc - acc_cyc, 1);
    chk("t2_first", last_wf, 32'h2000);
    chk("t2_last", last_wl, 32'h20FF);
    chk("t2_pend", pend, 1);
    flush();
    idle(1);
    chk("t2_flushed", last_wf, 32'h3000);

    // both ports valid: alternate starting with req0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = 32'h10000 + 32'(i) * 32'h100;
      c = 32'h80000 + 32'(i) * 32'h100;
      cyc(1, a, a + 32'hF, 1, c, c + 32'hF, 0);
      port_q.push_back(acc_port);
    end
    for (int i = 0; i < 8; i++)
      chk("t3_port", port_q[i], i % 2);
    flush();
    idle(1);

    // timeout: write lands 16 edges after the accepting edge
    rq0(32'h40, 32'h40);
    fc = acc_cyc;
    idle(20);
    chk("t4_wr_lat", wr_cyc - fc, TO + 1);
    chk("t4_first", last_wf, 32'h40);
    chk("t4_idle", pend, 0);

    // malformed interval: accepted and dropped
    rq0(32'hA000, 32'hA0FF);
    w0 = wr_cnt;
    drops0 = m_drops;
    rq0(32'h500, 32'h4FF);
    chk("t5_ready", obs_r0, 1);
    chk("t5_writes", wr_cnt - w0, 0);
    chk("t5_pend", pend, 1);
    chk("t5_model_drop", m_drops - drops0, 1);
`ifdef OVF_CTRL_STATS_EN
    chk("t5_stat_drops", s_dr, 1);
`endif
    flush();
    idle(1);
    chk("t5_first", last_wf, 32'hA000);
    chk("t5_last", last_wl, 32'hA0FF);

    // top-of-space interval must not merge with a wrapped one
    rq0(32'hFFFF_FF00, 32'hFFFF_FFFF);
    rq0(32'h0, 32'h10);
    chk("t6_first", last_wf, 32'hFFFF_FF00);
    chk("t6_last", last_wl, 32'hFFFF_FFFF);
    chk("t6_pend", pend, 1);
    for (int i = 0; i < 40; i++) begin
      a = 32'h100000 + 32'(i) * 32'h100;
      rq0(a, a + 32'hF);
    end
    chk("t6_occ_sat", occ, BS);

    // reset while holding an interval
    rq0(32'h7000, 32'h70FF);
    chk("t7_pend", pend, 1);
    @(negedge clk);
    {v0, v1, fl} = 3'b000;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t7_rst");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("t7_no_wr", wr, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle(3);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit rv0, rv1, rfl;
      int pv;
      pv = (i / 100) % 2 == 0 ? 50 : 10;
      rv0 = $urandom_range(0, 99) < pv;
      rv1 = $urandom_range(0, 99) < pv;
      rfl = $urandom_range(0, 99) < 4;
      rnd_ivl(a, b);
      rnd_ivl(c, d);
      cyc(rv0, a, b, rv1, c, d, rfl);
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
